// File: rtl/led_line_writer_pkg.sv
// Shared constants and types for the ledpanel row writer and
// other sources that drive the ledpanel ctrl bus.
package led_line_writer_pkg;

  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 32;
  localparam logic [3:0] WR_EN = 4'b0111;
  localparam int ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [4:0]  num;
    logic [31:0] bits;
    logic [23:0] color;
  } line_t;

  // Column-major byte address: one 32-bit word per pixel.
  function automatic logic [15:0] pix_addr(
    input logic [15:0] col,
    input logic [15:0] row,
    input int          row_shift
  );
    logic [15:0] word;
    word = (col << row_shift) + row;
    return word << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/led_line_buf.sv
// Two-slot line queue: active slot is drained by the writer,
// pending slot holds the next line.
module led_line_buf
  import led_line_writer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  line_t in_line,
  input  logic  pop,
  output logic  out_valid,
  output line_t out_line,
  output logic  pend_valid
);

  line_t act_q;
  line_t pend_q;
  logic  act_v;
  logic  pend_v;
  logic  push;

  assign in_ready   = !pend_v;
  assign push       = in_valid && in_ready;
  assign out_valid  = act_v;
  assign out_line   = act_q;
  assign pend_valid = pend_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_v  <= 1'b0;
      pend_v <= 1'b0;
      act_q  <= '0;
      pend_q <= '0;
    end else if (pop) begin
      // push implies pending empty, so the new line goes straight to active
      act_v  <= pend_v || push;
      act_q  <= push ? in_line : pend_q;
      pend_v <= 1'b0;
    end else if (push) begin
      if (act_v) begin
        pend_q <= in_line;
        pend_v <= 1'b1;
      end else begin
        act_q <= in_line;
        act_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_line_writer.sv
// Expands queued row bitmaps into single-pixel writes on the
// ledpanel ctrl bus, one acknowledged write per column.
module led_line_writer
  import led_line_writer_pkg::*;
#(
  parameter int          COLS     = COLS_DEF,
  parameter int          ROWS     = ROWS_DEF,
  parameter logic [23:0] BG_COLOR = 24'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_valid,
  output logic        line_ready,
  input  logic [4:0]  line_num,
  input  logic [31:0] line_bits,
  input  logic [23:0] line_color,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [31:0] ctrl_wdat,
  input  logic        ctrl_done,
  output logic        line_done,
  output logic        busy
);

  localparam int CW = $clog2(COLS);
  localparam int RS = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [15:0]   ROW_MAX  = 16'(ROWS - 1);

  line_t   in_line;
  line_t   act;
  logic    act_v;
  logic    pend_v;
  logic    pop;

  state_t  state, state_n;
  logic [CW-1:0] col, col_n;
  logic [3:0]    wr_n;
  logic [15:0]   addr_n;
  logic [31:0]   wdat_n;
  logic [15:0]   num16;
  logic [15:0]   row;
  logic [15:0]   pix_a;
  logic [31:0]   pix_d;

  assign in_line = '{num: line_num, bits: line_bits, color: line_color};

  led_line_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (line_valid),
    .in_ready  (line_ready),
    .in_line   (in_line),
    .pop       (pop),
    .out_valid (act_v),
    .out_line  (act),
    .pend_valid(pend_v)
  );

  // Vertical flip; out-of-range rows clamp to the last panel row.
  assign num16 = {11'b0, act.num};
  assign row   = (num16 > ROW_MAX) ? 16'h0 : ROW_MAX - num16;
  assign pix_a = pix_addr(16'(col), row, RS);
  assign pix_d = act.bits[col] ? {8'h00, act.color}
                               : {8'h00, BG_COLOR};

  assign line_done = (state == S_DONE);
  assign busy      = (state != S_IDLE) || pend_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      col       <= '0;
      ctrl_wr   <= '0;
      ctrl_addr <= '0;
      ctrl_wdat <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      ctrl_wr   <= wr_n;
      ctrl_addr <= addr_n;
      ctrl_wdat <= wdat_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    wr_n    = ctrl_wr;
    addr_n  = ctrl_addr;
    wdat_n  = ctrl_wdat;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (act_v) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        wr_n    = WR_EN;
        addr_n  = pix_a;
        wdat_n  = pix_d;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (ctrl_done) begin
          wr_n = '0;
          if (col == LAST_COL) begin
            state_n = S_DONE;
          end else begin
            col_n   = col + 1'b1;
            state_n = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        pop     = 1'b1;
        col_n   = '0;
        state_n = pend_v ? S_ISSUE : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_line_writer.sv
// Directed bench for led_line_writer with a behavioural ledpanel
// responder that acks each write after a programmable delay.
module tb_led_line_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_valid = 1'b0;
  logic        line_ready;
  logic [4:0]  line_num = '0;
  logic [31:0] line_bits = '0;
  logic [23:0] line_color = '0;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic        ctrl_done;
  logic        resp_done = 1'b0;
  logic        man_done = 1'b0;
  logic        line_done;
  logic        busy;

  int total = 0;
  int bad = 0;

  int ack_delay = 0;
  bit auto_ack = 1'b0;

  logic [15:0] log_a[$];
  logic [31:0] log_d[$];
  int          done_cnt = 0;
  int          wr_starts = 0;
  int          stab_err = 0;
  int          wcnt = 0;
  bit          acked = 1'b0;
  logic [3:0]  prev_wr = '0;
  logic [15:0] hold_a = '0;
  logic [31:0] hold_d = '0;

  assign ctrl_done = resp_done | man_done;

  always #5 clk = ~clk;

  led_line_writer dut (
    .clk       (clk),
    .reset     (reset),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .line_num  (line_num),
    .line_bits (line_bits),
    .line_color(line_color),
    .ctrl_wr   (ctrl_wr),
    .ctrl_addr (ctrl_addr),
    .ctrl_wdat (ctrl_wdat),
    .ctrl_done (ctrl_done),
    .line_done (line_done),
    .busy      (busy)
  );

  // ledpanel model: logs each write when it acks it
  always @(negedge clk) begin
    resp_done <= 1'b0;
    prev_wr   <= ctrl_wr;
    if (line_done) done_cnt <= done_cnt + 1;
    if (ctrl_wr != 0 && prev_wr == 0) begin
      wr_starts <= wr_starts + 1;
      hold_a    <= ctrl_addr;
      hold_d    <= ctrl_wdat;
    end else if (ctrl_wr != 0 &&
                 (ctrl_addr !== hold_a || ctrl_wdat !== hold_d)) begin
      stab_err <= stab_err + 1;
    end
    if (ctrl_wr == 0) begin
      acked <= 1'b0;
      wcnt  <= 0;
    end else if (auto_ack && !acked) begin
      if (wcnt >= ack_delay) begin
        resp_done <= 1'b1;
        acked     <= 1'b1;
        log_a.push_back(ctrl_addr);
        log_d.push_back(ctrl_wdat);
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  function automatic logic [15:0] exp_addr(input int c, input int r);
    return 16'((c * 32 + r) * 4);
  endfunction

  task automatic send_line(input logic [4:0] n, input logic [31:0] b,
                           input logic [23:0] c);
    int t = 0;
    @(negedge clk);
    line_valid = 1'b1;
    line_num   = n;
    line_bits  = b;
    line_color = c;
    while (line_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (line_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_line: line_ready=%b, required 1", line_ready);
    end
    @(posedge clk);
    #1 line_valid = 1'b0;
  endtask

  task automatic wait_line(input int limit);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (line_done !== 1'b1 && t < limit);
    total++;
    if (line_done !== 1'b1) begin
      bad++;
      $display("FAIL wait_line: line_done=%b after %0d cycles, required 1",
               line_done, t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (ctrl_wr !== 4'h0) begin bad++;
      $display("FAIL rst_wr: got %h, required 0", ctrl_wr); end
    if (ctrl_addr !== 16'h0) begin bad++;
      $display("FAIL rst_addr: got %h, required 0", ctrl_addr); end
    if (ctrl_wdat !== 32'h0) begin bad++;
      $display("FAIL rst_wdat: got %h, required 0", ctrl_wdat); end
    if (line_done !== 1'b0) begin bad++;
      $display("FAIL rst_done: got %b, required 0", line_done); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy: got %b, required 0", busy); end
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL rst_ready: got %b, required 1", line_ready); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int base;
    int cyc = 0;
    int dcyc = -1;
    logic [31:0] ew;
    ack_delay = 1;
    auto_ack  = 1'b1;
    base = log_a.size();
    send_line(5'd3, 32'h0000_0001, 24'hff0000);
    while (dcyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 2) begin
        total++;
        if (ctrl_wr !== 4'h0) begin bad++;
          $display("FAIL lat_dead c%0d: wr %h, required 0", cyc, ctrl_wr); end
      end
      if (cyc == 3) begin
        total++;
        if (ctrl_wr !== 4'b0111) begin bad++;
          $display("FAIL lat_first: wr %h, required 7", ctrl_wr); end
      end
      if (line_done === 1'b1) dcyc = cyc;
    end
    total++;
    if (dcyc != 98) begin bad++;
      $display("FAIL line_time: done at %0d, required 98", dcyc); end
    @(negedge clk);
    total++;
    if (line_done !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL one_done: done %b busy %b, required 0 0",
               line_done, busy); end
    total++;
    if (log_a.size() - base != 32) begin bad++;
      $display("FAIL single_cnt: %0d writes, required 32",
               log_a.size() - base); end
    else begin
      for (int c = 0; c < 32; c++) begin
        ew = (c == 0) ? 32'h00ff0000 : 32'h0;
        total++;
        if (log_a[base+c] !== exp_addr(c, 28) || log_d[base+c] !== ew) begin
          bad++;
          $display("FAIL single_px%0d: %h/%h, required %h/%h", c,
                   log_a[base+c], log_d[base+c], exp_addr(c, 28), ew);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int t = 0;
    int nd = 0;
    int d1 = -1;
    int w2 = -1;
    logic [31:0] b30 = 32'hAAAA_5555;
    logic [31:0] b31 = 32'h8000_0001;
    logic [31:0] ew;
    logic [15:0] ea;
    ack_delay = 0;
    auto_ack  = 1'b1;
    base = log_a.size();
    @(negedge clk);
    line_valid = 1'b1;
    line_num   = 5'd30;
    line_bits  = b30;
    line_color = 24'h00ff00;
    total++;
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_rdy0: %b, required 1", line_ready); end
    @(negedge clk);
    line_num   = 5'd31;
    line_bits  = b31;
    line_color = 24'h0000ff;
    total++;
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_rdy1: %b, required 1", line_ready); end
    @(negedge clk);
    total += 2;
    if (line_ready !== 1'b0) begin bad++;
      $display("FAIL b2b_full: ready %b, required 0", line_ready); end
    if (busy !== 1'b1) begin bad++;
      $display("FAIL b2b_busy: %b, required 1", busy); end
    line_valid = 1'b0;
    while (nd < 2 && t < 1000) begin
      @(negedge clk);
      t++;
      if (nd == 1 && w2 < 0 && ctrl_wr != 0) w2 = t;
      if (line_done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = t;
      end
    end
    total += 2;
    if (nd != 2) begin bad++;
      $display("FAIL b2b_dones: %0d, required 2", nd); end
    if (w2 - d1 != 2) begin bad++;
      $display("FAIL b2b_gap: %0d, required 2", w2 - d1); end
    total++;
    if (log_a.size() - base != 64) begin bad++;
      $display("FAIL b2b_cnt: %0d writes, required 64",
               log_a.size() - base); end
    else begin
      for (int i = 0; i < 64; i++) begin
        if (i < 32) begin
          ea = exp_addr(i, 1);
          ew = b30[i] ? 32'h0000ff00 : 32'h0;
        end else begin
          ea = exp_addr(i - 32, 0);
          ew = b31[i-32] ? 32'h000000ff : 32'h0;
        end
        total++;
        if (log_a[base+i] !== ea || log_d[base+i] !== ew) begin
          bad++;
          $display("FAIL b2b_px%0d: %h/%h, required %h/%h", i,
                   log_a[base+i], log_d[base+i], ea, ew);
        end
      end
    end
    @(negedge clk);
    total++;
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_rdy_end: %b, required 1", line_ready); end
  endtask

  task automatic test_delayed_ack();
    int base;
    int ws0;
    int se0;
    logic [31:0] b = 32'h0F0F_F0F0;
    logic [31:0] ew;
    ack_delay = 7;
    auto_ack  = 1'b1;
    @(negedge clk);
    #1;
    base = log_a.size();
    ws0  = wr_starts;
    se0  = stab_err;
    send_line(5'd7, b, 24'h123456);
    wait_line(2000);
    #1;
    total += 3;
    if (stab_err != se0) begin bad++;
      $display("FAIL dly_stable: %0d changes, required 0", stab_err - se0); end
    if (wr_starts - ws0 != 32) begin bad++;
      $display("FAIL dly_writes: %0d, required 32", wr_starts - ws0); end
    if (log_a.size() - base != 32) begin bad++;
      $display("FAIL dly_acks: %0d, required 32", log_a.size() - base); end
    else begin
      for (int c = 0; c < 32; c++) begin
        ew = b[c] ? 32'h00123456 : 32'h0;
        total++;
        if (log_a[base+c] !== exp_addr(c, 24) || log_d[base+c] !== ew) begin
          bad++;
          $display("FAIL dly_px%0d: %h/%h, required %h/%h", c,
                   log_a[base+c], log_d[base+c], exp_addr(c, 24), ew);
        end
      end
    end
  endtask

  task automatic test_spurious_done();
    int base;
    int ws0;
    auto_ack = 1'b0;
    @(negedge clk);
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    man_done = 1'b0;
    total += 2;
    if (ctrl_wr !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL spur_idle: wr %h busy %b, required 0 0", ctrl_wr, busy); end
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL spur_idle_rdy: %b, required 1", line_ready); end
    base = log_a.size();
    #1 ws0 = wr_starts;
    send_line(5'd9, 32'h0000_0002, 24'habcdef);
    man_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    man_done = 1'b0;
    total++;
    if (ctrl_wr !== 4'b0111 || ctrl_addr !== 16'h0058 ||
        ctrl_wdat !== 32'h0) begin bad++;
      $display("FAIL spur_issue: %h %h %h, required 7 0058 0",
               ctrl_wr, ctrl_addr, ctrl_wdat); end
    repeat (5) @(negedge clk);
    total++;
    if (ctrl_wr !== 4'b0111 || ctrl_addr !== 16'h0058) begin bad++;
      $display("FAIL spur_hold: %h %h, required 7 0058", ctrl_wr, ctrl_addr); end
    ack_delay = 0;
    auto_ack  = 1'b1;
    wait_line(400);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    #1;
    total += 3;
    if (ctrl_wr !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL spur_done: wr %h busy %b, required 0 0", ctrl_wr, busy); end
    if (wr_starts - ws0 != 32) begin bad++;
      $display("FAIL spur_writes: %0d, required 32", wr_starts - ws0); end
    if (log_a.size() - base != 32) begin bad++;
      $display("FAIL spur_cnt: %0d, required 32", log_a.size() - base); end
    else begin
      total++;
      if (log_a[base] !== 16'h0058 || log_d[base] !== 32'h0 ||
          log_a[base+1] !== 16'h00d8 || log_d[base+1] !== 32'h00abcdef) begin
        bad++;
        $display("FAIL spur_px: %h/%h %h/%h, required 0058/0 00d8/00abcdef",
                 log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    int base;
    int t = 0;
    int dc0;
    int ws0;
    ack_delay = 3;
    auto_ack  = 1'b1;
    base = log_a.size();
    send_line(5'd10, 32'hFFFF_FFFF, 24'h111111);
    send_line(5'd11, 32'hFFFF_FFFF, 24'h222222);
    while (!(log_a.size() - base == 17 && ctrl_wr != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (!(log_a.size() - base == 17 && ctrl_wr != 0)) begin bad++;
      $display("FAIL mid_reach: %0d acks, required 17", log_a.size() - base); end
    #1 reset = 1'b1;
    #1;
    total += 6;
    if (ctrl_wr !== 4'h0) begin bad++;
      $display("FAIL mid_wr: %h, required 0", ctrl_wr); end
    if (ctrl_addr !== 16'h0) begin bad++;
      $display("FAIL mid_addr: %h, required 0", ctrl_addr); end
    if (ctrl_wdat !== 32'h0) begin bad++;
      $display("FAIL mid_wdat: %h, required 0", ctrl_wdat); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL mid_busy: %b, required 0", busy); end
    if (line_ready !== 1'b1) begin bad++;
      $display("FAIL mid_ready: %b, required 1", line_ready); end
    if (line_done !== 1'b0) begin bad++;
      $display("FAIL mid_done: %b, required 0", line_done); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    dc0 = done_cnt;
    ws0 = wr_starts;
    repeat (10) @(negedge clk);
    #1;
    total += 2;
    if (done_cnt != dc0 || busy !== 1'b0) begin bad++;
      $display("FAIL mid_quiet: dones %0d busy %b, required 0 0",
               done_cnt - dc0, busy); end
    if (wr_starts != ws0) begin bad++;
      $display("FAIL mid_dropped: %0d writes, required 0", wr_starts - ws0); end
    base = log_a.size();
    ack_delay = 0;
    send_line(5'd2, 32'h0000_0001, 24'h445566);
    wait_line(400);
    total++;
    if (log_a.size() - base != 32 ||
        log_a[base] !== 16'h0074 || log_d[base] !== 32'h00445566 ||
        log_a[base+1] !== 16'h00f4 || log_d[base+1] !== 32'h0) begin
      bad++;
      $display("FAIL mid_restart: n=%0d %h/%h, required 32 0074/00445566",
               log_a.size() - base, log_a[base], log_d[base]);
    end
  endtask

  task automatic test_last_row();
    int base;
    ack_delay = 0;
    auto_ack  = 1'b1;
    base = log_a.size();
    send_line(5'd31, 32'hFFFF_FFFF, 24'hc0ffee);
    wait_line(400);
    total++;
    if (log_a.size() - base != 32) begin bad++;
      $display("FAIL row0_cnt: %0d, required 32", log_a.size() - base); end
    else begin
      for (int c = 0; c < 32; c++) begin
        total++;
        if (log_a[base+c] !== exp_addr(c, 0) ||
            log_d[base+c] !== 32'h00c0ffee) begin
          bad++;
          $display("FAIL row0_px%0d: %h/%h, required %h/00c0ffee", c,
                   log_a[base+c], log_d[base+c], exp_addr(c, 0));
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_delayed_ack();
    test_spurious_done();
    test_reset_mid_line();
    test_last_row();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
